// File: rtl/uart_operand_collector_if.sv
// Bundle of the UART byte stream into the collector and the operand set it
// presents to the 64-bit carry-select adder.
interface uart_operand_collector_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [63:0] birinci;
    logic [63:0] ikinci;
    logic        anacin;
    logic        op_valid;
    logic        busy;
    logic        frame_err;

    // Byte source side: drives the UART stream, observes the operand set.
    modport master (
        output rx_data, rx_valid,
        input  birinci, ikinci, anacin, op_valid, busy, frame_err
    );

    // Collector side: consumes the UART stream, drives the operand set.
    modport slave (
        input  rx_data, rx_valid,
        output birinci, ikinci, anacin, op_valid, busy, frame_err
    );
endinterface

// File: rtl/uart_operand_collector.sv
// Collects a 17-byte UART frame (8 bytes A, 8 bytes B, 1 carry byte, all
// little-endian) into shadow registers and applies the complete set to the
// adder inputs in one step. An inter-byte timeout drops a broken frame.
module uart_operand_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_operand_collector_if.slave bus
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic [63:0]      sha_q;
    logic [63:0]      shb_q;
    logic [63:0]      birinci_q;
    logic [63:0]      ikinci_q;
    logic             anacin_q;
    logic             op_valid_q;
    logic             busy_q;
    logic             frame_err_q;

    // Byte slot inside the current operand: byte k sits at bits [8k+7:8k].
    logic [5:0]       slot;
    assign slot = {cnt_q, 3'b000};

    // Frame FSM, byte counter, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            tmo_q       <= '0;
            // NOTE: shadows are plain flops and are reset with everything else,
            // so a frame cut by reset can never leak into a later operand set.
            sha_q       <= '0;
            shb_q       <= '0;
            birinci_q   <= '0;
            ikinci_q    <= '0;
            anacin_q    <= 1'b0;
            op_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; every branch below reads
            // the pre-edge values of state_q/cnt_q/tmo_q, never a half-updated one.
            op_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (bus.rx_valid) begin
                // A byte always wins, even in the cycle the timeout would fire.
                tmo_q <= '0;
                unique case (state_q)
                    LOAD_A: begin
                        sha_q[slot +: 8] <= bus.rx_data;
                        cnt_q            <= cnt_q + 3'd1;
                        busy_q           <= 1'b1;
                        if (cnt_q == 3'd7) state_q <= LOAD_B;
                    end
                    LOAD_B: begin
                        shb_q[slot +: 8] <= bus.rx_data;
                        cnt_q            <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= LOAD_C;
                    end
                    LOAD_C: begin
                        birinci_q  <= sha_q;
                        ikinci_q   <= shb_q;
                        anacin_q   <= bus.rx_data[0];
                        op_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= LOAD_A;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= LOAD_A;
                    end
                endcase
            end else if (!busy_q) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_MAX) begin
                // Abort: shadow bytes are stale and get overwritten by the next
                // frame; the outputs keep the last completed set.
                frame_err_q <= 1'b1;
                busy_q      <= 1'b0;
                cnt_q       <= '0;
                tmo_q       <= '0;
                state_q     <= LOAD_A;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    assign bus.birinci   = birinci_q;
    assign bus.ikinci    = ikinci_q;
    assign bus.anacin    = anacin_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_operand_collector.sv
// Directed bench for uart_operand_collector with TIMEOUT_CYCLES=20.
module tb_uart_operand_collector;
    localparam int unsigned TMO = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Pulse bookkeeping, updated on the rising edge from pre-edge values.
    int   cyc;
    int   ov_cnt;
    int   ov_last;
    int   ov_prev;
    int   fe_cnt;

    uart_operand_collector_if bus ();

    uart_operand_collector #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count op_valid / frame_err pulses and remember when op_valid fired.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.op_valid === 1'b1) begin
            ov_cnt  = ov_cnt + 1;
            ov_prev = ov_last;
            ov_last = cyc;
        end
        if (bus.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: presents one byte for exactly one rising edge.
    task automatic put(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] fbyte(input logic [63:0] a, input logic [63:0] b,
                                         input logic [7:0] c, input int idx);
        if (idx < 8)       return a[idx*8 +: 8];
        else if (idx < 16) return b[(idx-8)*8 +: 8];
        else               return c;
    endfunction

    task automatic send_range(input logic [63:0] a, input logic [63:0] b,
                              input logic [7:0] c, input int first, input int last);
        for (int i = first; i <= last; i++) put(fbyte(a, b, c, i));
    endtask

    task automatic check_ops(input string tag, input logic [63:0] a,
                             input logic [63:0] b, input logic c);
        check({tag, "_birinci"}, bus.birinci, a);
        check({tag, "_ikinci"},  bus.ikinci,  b);
        check({tag, "_anacin"},  {63'd0, bus.anacin}, {63'd0, c});
    endtask

    int ov0;
    int fe0;
    int waited;

    initial begin
        checks = 0; failures = 0;
        cyc = 0; ov_cnt = 0; ov_last = 0; ov_prev = 0; fe_cnt = 0;
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state.
        #3;
        check_ops("rst", 64'd0, 64'd0, 1'b0);
        check("rst_op_valid",  {63'd0, bus.op_valid},  64'd0);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        check("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

        // Nominal frame: A=3846, B=2342, carry byte 01.
        ov0 = ov_cnt;
        send_range(64'd3846, 64'd2342, 8'h01, 0, 15);
        check("nom_busy_before_last", {63'd0, bus.busy}, 64'd1);
        put(8'h01);
        check("nom_op_valid_pulse", {63'd0, bus.op_valid}, 64'd1);
        check("nom_busy_after", {63'd0, bus.busy}, 64'd0);
        check_ops("nom", 64'd3846, 64'd2342, 1'b1);
        check("nom_adder_sum", bus.birinci + bus.ikinci + {63'd0, bus.anacin}, 64'd6189);
        idle(1);
        check("nom_op_valid_low", {63'd0, bus.op_valid}, 64'd0);
        check("nom_op_valid_count", 64'(ov_cnt - ov0), 64'd1);

        // Stability: first 10 bytes of the next frame leave outputs alone.
        ov0 = ov_cnt;
        send_range(64'd2006, 64'd2006, 8'h00, 0, 9);
        idle(1);
        check_ops("stab_hold", 64'd3846, 64'd2342, 1'b1);
        check("stab_no_op_valid", 64'(ov_cnt - ov0), 64'd0);
        check("stab_busy", {63'd0, bus.busy}, 64'd1);
        send_range(64'd2006, 64'd2006, 8'h00, 10, 16);
        check_ops("stab_done", 64'd2006, 64'd2006, 1'b0);

        // Timeout after 5 bytes: frame_err exactly TMO+1 cycles later.
        idle(2);
        fe0 = fe_cnt;
        send_range(64'h1122_3344_5566_7788, 64'd0, 8'h00, 0, 4);
        waited = 0;
        while (bus.frame_err !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_delay", 64'(waited), 64'(TMO + 1));
        check("tmo_busy", {63'd0, bus.busy}, 64'd0);
        check_ops("tmo_hold", 64'd2006, 64'd2006, 1'b0);
        idle(1);
        check("tmo_pulse_count", 64'(fe_cnt - fe0), 64'd1);
        send_range(64'd12, 64'd300, 8'hFE, 0, 16);
        check_ops("tmo_recover", 64'd12, 64'd300, 1'b0);

        // Byte arrives in the very cycle the timeout would fire.
        idle(2);
        fe0 = fe_cnt;
        send_range(64'd200, 64'd16, 8'h01, 0, 4);
        idle(TMO);
        put(fbyte(64'd200, 64'd16, 8'h01, 5));
        check("coll_no_err_now", {63'd0, bus.frame_err}, 64'd0);
        check("coll_busy", {63'd0, bus.busy}, 64'd1);
        send_range(64'd200, 64'd16, 8'h01, 6, 16);
        check_ops("coll", 64'd200, 64'd16, 1'b1);
        idle(1);
        check("coll_no_err_count", 64'(fe_cnt - fe0), 64'd0);

        // Back-to-back: 34 strobes on 34 consecutive cycles.
        idle(2);
        ov0 = ov_cnt;
        send_range(64'd0, 64'd0, 8'h01, 0, 16);
        send_range(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 16);
        idle(1);
        check("b2b_op_valid_count", 64'(ov_cnt - ov0), 64'd2);
        check("b2b_spacing", 64'(ov_last - ov_prev), 64'd17);
        check_ops("b2b", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Reset mid-frame clears everything immediately.
        send_range(64'd9, 64'd9, 8'h00, 0, 4);
        #1 rst_n = 1'b0;
        #1;
        check_ops("midrst", 64'd0, 64'd0, 1'b0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("midrst_release_busy", {63'd0, bus.busy}, 64'd0);
        send_range(64'd5, 64'd7, 8'h01, 0, 16);
        check_ops("midrst_frame", 64'd5, 64'd7, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
